fir_alu: RTL and testbench

- Time-multiplexed 64-tap, 16-bit signed FIR filter with one shared multiply-accumulate unit.
- Accepts one input sample per 65-clock frame: 640 kHz clock, about 10 kHz sample rate.
- Converts each fixed-point sum to IEEE-754 half precision (FX2FP) and holds it as y_float until the next frame.
- Sits between the sampled-data front end and downstream float consumers.

---
 rtl/fir_alu.sv | 62 ++++++
 tb/tb_fir_alu.sv | 118 +++++++++++
 2 files changed

// File: rtl/fir_alu.sv
// fir_alu: time-multiplexed FIR filter with one shared MAC and IEEE half-precision output
module fir_alu #(
  parameter int    TAPS      = 64,
  parameter int    DW        = 16,
  parameter string COEF_FILE = ""
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic signed [DW-1:0] x_in,
  output logic        [15:0]   y_float
);
  localparam int AW = 2*DW + $clog2(TAPS);
  localparam int FB = 2*(DW-1);
  localparam int CW = $clog2(TAPS+1);
  localparam int IW = $clog2(TAPS);
  localparam int PW = $clog2(AW);
  typedef logic signed [DW-1:0] coef_t [TAPS];
  function automatic coef_t load_coef();
    coef_t t;
    t = '{default: '0};
    t[0] = DW'(1) << (DW-2);
    return t;
  endfunction
  coef_t b = load_coef();
  logic signed [DW-1:0]   d [TAPS];
  logic        [CW-1:0]   cnt;
  logic        [IW-1:0]   idx;
  logic signed [AW-1:0]   acc;
  logic signed [2*DW-1:0] prod;
  logic        [AW-1:0]   mag;
  logic        [PW-1:0]   p;
  logic        [15:0]     half;
  always_comb begin
    idx  = IW'(cnt - 1'b1);
    prod = b[idx] * d[idx];
  end
  always_comb begin
    mag = acc[AW-1] ? -$unsigned(acc) : $unsigned(acc);
    p = '0;
    for (int i = 0; i < AW; i++) if (mag[i]) p = PW'(i);
    half = (p < PW'(FB-14)) ? {acc[AW-1], 15'd0}
                            : {acc[AW-1], 5'(p - PW'(FB-15)), 10'(mag >> (p - PW'(10)))};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      acc     <= '0;
      y_float <= '0;
      d       <= '{default: '0};
    end else begin
      cnt <= (cnt == CW'(TAPS)) ? '0 : cnt + 1'b1;
      if (cnt == '0) begin
        d[0] <= x_in;
        for (int k = 1; k < TAPS; k++) d[k] <= d[k-1];
        y_float <= half;
        acc     <= '0;
      end else begin
        acc <= acc + AW'(prod);
      end
    end
  end
endmodule

// File: tb/tb_fir_alu.sv
// tb_fir_alu: random and directed frames checked against a sum-of-products reference model
module tb_fir_alu;
  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic signed [15:0] x_in = '0;
  logic        [15:0] y_float;
  int                 n_chk = 0;
  int                 n_pass = 0;
  logic signed [15:0] tb_b [64];
  logic signed [15:0] hist [$];
  logic        [15:0] pend, cur;
  fir_alu dut (.clk(clk), .reset(reset), .x_in(x_in), .y_float(y_float));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
  endtask
  function automatic logic [15:0] to_half(input longint s);
    longint m;
    int p;
    logic [15:0] mant;
    if (s == 0) return 16'h0000;
    m = (s < 0) ? -s : s;
    p = 0;
    while ((m >> (p + 1)) != 0) p++;
    if (p - 30 < -14) return {s < 0, 15'd0};
    mant = 16'(((p >= 10) ? (m >> (p - 10)) : (m << (10 - p))) & 1023);
    return {s < 0, 5'(p - 30 + 15), mant[9:0]};
  endfunction
  function automatic logic [15:0] model_out();
    longint s = 0;
    for (int k = 0; k < 64; k++) s += longint'(tb_b[k]) * longint'(hist[k]);
    return to_half(s);
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic clear_model();
    hist = {};
    repeat (64) hist.push_back(16'sd0);
    pend = 16'h0000;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    repeat (3) step();
    chk("reset", y_float, 16'h0000);
    reset = 1'b0;
    clear_model();
  endtask
  task automatic set_b(input int k, input logic [15:0] v);
    dut.b[k] = v;
    tb_b[k] = v;
  endtask
  task automatic zero_b();
    for (int k = 0; k < 64; k++) set_b(k, 16'h0000);
  endtask
  task automatic run_frame(input logic [15:0] x);
    x_in = x;
    step();
    chk("frame_start", y_float, pend);
    cur = pend;
    hist.push_front(x);
    void'(hist.pop_back());
    pend = model_out();
    x_in = 16'($urandom);
    repeat (64) step();
    chk("frame_hold", y_float, cur);
  endtask
  initial begin
    for (int k = 0; k < 64; k++) tb_b[k] = 16'sd0;
    tb_b[0] = 16'sh4000;
    do_reset();
    run_frame(16'h0000);
    run_frame(16'h0000);
    run_frame(16'h4000);
    run_frame(16'h8000);
    chk("imp_pos", y_float, 16'h3400);
    run_frame(16'h0000);
    chk("imp_neg", y_float, 16'hB800);
    run_frame(16'h0001);
    run_frame(16'hFFFF);
    chk("flush_pos", y_float, 16'h0000);
    run_frame(16'h0000);
    chk("flush_neg", y_float, 16'h8000);
    for (int k = 0; k < 64; k++) set_b(k, 16'h0200);
    do_reset();
    repeat (65) run_frame(16'h7FFF);
    chk("step_final", y_float, 16'h3BFF);
    zero_b();
    set_b(0, 16'h4000);
    do_reset();
    run_frame(16'h4000);
    x_in = 16'h4000;
    step();
    chk("abort_start", y_float, pend);
    repeat (29) step();
    reset = 1'b1;
    step();
    chk("abort_reset", y_float, 16'h0000);
    reset = 1'b0;
    clear_model();
    run_frame(16'h4000);
    run_frame(16'h0000);
    chk("abort_retry", y_float, 16'h3400);
    zero_b();
    set_b(5, 16'h4000);
    do_reset();
    run_frame(16'h4000);
    repeat (8) run_frame(16'h0000);
    for (int k = 0; k < 64; k++) set_b(k, 16'($urandom));
    do_reset();
    repeat (40) run_frame(16'($urandom));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
